restoring_divider: RTL and testbench

- Sequential unsigned divider that computes quotient and remainder by shift-and-subtract, one quotient bit per clock.
- It is the inverse-operation companion to the team's combinational ripple-carry adder, and uses a ripple-borrow subtractor as its datapath.
- It sits behind the board switch/LED test wrapper.
- It uses a start/done handshake so that one operation is in flight at a time.

---
 rtl/restoring_divider_pkg.sv | 19 +
 rtl/ripple_subtractor.sv | 24 ++
 rtl/restoring_divider.sv | 106 ++++++++++
 tb/tb_restoring_divider.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/restoring_divider_pkg.sv
// Shared types and sizing for the restoring divider.
package restoring_divider_pkg;

    localparam int unsigned DefaultWidth = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StZero
    } state_e;

    // Iteration counter must hold the value WIDTH itself.
    function automatic int unsigned count_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    localparam int unsigned DefaultCountWidth = count_width(DefaultWidth);

endpackage

// File: rtl/ripple_subtractor.sv
// Combinational ripple-borrow subtractor: diff = x - y, borrow_out set when x < y.
module ripple_subtractor #(
    parameter int unsigned N = restoring_divider_pkg::DefaultWidth + 1
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] diff,
    output logic         borrow_out
);

    logic [N:0] w_borrow;

    assign w_borrow[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_bit
        logic w_xy;
        assign w_xy            = x[i] ^ y[i];
        assign diff[i]         = w_xy ^ w_borrow[i];
        assign w_borrow[i + 1] = (~x[i] & y[i]) | (~w_xy & w_borrow[i]);
    end

    assign borrow_out = w_borrow[N];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = count_width(WIDTH);

    state_e            r_state;
    logic [WIDTH:0]    r_r;
    logic [WIDTH-1:0]  r_q;
    logic [WIDTH-1:0]  r_d;
    logic [CntW-1:0]   r_count;

    logic [WIDTH:0]    w_r_shift;
    logic [WIDTH:0]    w_trial;
    logic              w_borrow;
    logic [WIDTH:0]    w_r_next;
    logic [WIDTH-1:0]  w_q_next;

    // Shift {R,Q} left by one; the bit leaving Q enters R.
    assign w_r_shift = {r_r[WIDTH-1:0], r_q[WIDTH-1]};

    ripple_subtractor #(
        .N (WIDTH + 1)
    ) u_sub (
        .x          (w_r_shift),
        .y          ({1'b0, r_d}),
        .diff       (w_trial),
        .borrow_out (w_borrow)
    );

    assign w_r_next = w_borrow ? w_r_shift : w_trial;
    assign w_q_next = {r_q[WIDTH-2:0], ~w_borrow};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_r         <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_count     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_q  <= dividend;
                        busy <= 1'b1;
                        if (divisor != '0) begin
                            r_d     <= divisor;
                            r_r     <= '0;
                            r_count <= CntW'(WIDTH);
                            r_state <= StRun;
                        end else begin
                            r_state <= StZero;
                        end
                    end
                end
                StRun: begin
                    r_r     <= w_r_next;
                    r_q     <= w_q_next;
                    r_count <= r_count - CntW'(1);
                    if (r_count == CntW'(1)) begin
                        quotient    <= w_q_next;
                        remainder   <= w_r_next[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                StZero: begin
                    quotient    <= '1;
                    remainder   <= r_q;
                    div_by_zero <= 1'b1;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    r_state     <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and exhaustive checks for the 4-bit restoring divider.
module tb_restoring_divider;

    logic       clock;
    logic       reset;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    restoring_divider #(
        .WIDTH (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] eq, input logic [3:0] er,
                                 input logic ez);
        check({tag, "_q"}, 32'(quotient), 32'(eq));
        check({tag, "_r"}, 32'(remainder), 32'(er));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
    endtask

    // Issues one request and returns in the cycle where done is high.
    task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] eq, input logic [3:0] er, input logic ez);
        int lat;
        int busy_cnt;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        step();
        start    = 1'b0;
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            step();
            lat++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_lat"}, 32'(lat), (b == 4'd0) ? 32'd2 : 32'd5);
        check({tag, "_busycyc"}, 32'(busy_cnt), (b == 4'd0) ? 32'd1 : 32'd4);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check_outputs(tag, eq, er, ez);
    endtask

    initial begin
        int lat;
        int done_seen;
        logic [3:0] mq;
        logic [3:0] mr;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_outputs("rst", 4'd0, 4'd0, 1'b0);
        reset = 1'b0;
        step();

        do_op("13div3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
        step();
        check("13div3_pulse", 32'(done), 32'd0);
        check_outputs("13div3_hold", 4'd4, 4'd1, 1'b0);

        do_op("15div1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
        step();
        do_op("2div7", 4'd2, 4'd7, 4'd0, 4'd2, 1'b0);
        step();
        step();
        step();
        check_outputs("2div7_hold", 4'd0, 4'd2, 1'b0);

        do_op("9div0", 4'd9, 4'd0, 4'd15, 4'd9, 1'b1);
        step();
        check("9div0_pulse", 32'(done), 32'd0);
        check("9div0_idle", 32'(busy), 32'd0);

        // Second request during RUN must be ignored.
        start    = 1'b1;
        dividend = 4'd12;
        divisor  = 4'd5;
        step();
        start = 1'b0;
        step();
        start    = 1'b1;
        dividend = 4'd7;
        divisor  = 4'd7;
        step();
        step();
        start = 1'b0;
        lat   = 4;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        check("ign_lat", 32'(lat), 32'd5);
        check_outputs("ign", 4'd2, 4'd2, 1'b0);
        step();
        step();
        check("ign_no_second", 32'(busy), 32'd0);

        // Asynchronous reset mid-operation.
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd4;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check_outputs("midrst", 4'd0, 4'd0, 1'b0);
        step();
        reset     = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done || busy) done_seen = 1;
        end
        check("midrst_quiet", 32'(done_seen), 32'd0);
        do_op("6div2", 4'd6, 4'd2, 4'd3, 4'd0, 1'b0);
        step();

        // Back-to-back: second start lands in the done cycle of the first.
        do_op("10div3", 4'd10, 4'd3, 4'd3, 4'd1, 1'b0);
        do_op("8div2", 4'd8, 4'd2, 4'd4, 4'd0, 1'b0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    mq = 4'hF;
                    mr = 4'(a);
                end else begin
                    mq = 4'(a / b);
                    mr = 4'(a % b);
                end
                do_op($sformatf("sw_%0d_%0d", a, b), 4'(a), 4'(b), mq, mr, b == 0);
            end
        end

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
